// File: rtl/int_calc_ctrl.sv
// int_calc_ctrl: single-outstanding request sequencer for the integer
// calculation datapath. One request is accepted in IDLE. Its operands are
// held on calc_a/calc_b while the selected unit's fixed latency elapses.
// The result and flags are then captured into a response that stays valid
// until it is taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The requester keeps valid and its payload stable until that
// edge. The controller keeps rsp_valid, rsp_data and rsp_flags stable until
// it sees rsp_ready at a rising edge.
module int_calc_ctrl #(
  parameter int MUL_LAT = 6,
  parameter int DIV_LAT = 36,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [31:0] req_b,
  output logic [63:0] calc_a,
  output logic [31:0] calc_b,
  input  logic [31:0] int_add,
  input  logic [31:0] int_sub,
  input  logic [63:0] int_mul,
  input  logic [31:0] int_div,
  input  logic [31:0] int_mod,
  input  logic        addCo,
  input  logic        addCy,
  input  logic        subCo,
  input  logic        subCy,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        busy,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        calc_a_q;
  logic [31:0]        calc_b_q;
  logic               rsp_valid_q;
  logic [63:0]        rsp_data_q;
  logic [3:0]         rsp_flags_q;

  logic [63:0]        cap_data_d;
  logic [3:0]         cap_flags_d;
  logic               req_illegal;
  logic               req_dbz;
  logic [63:0]        skip_data_d;
  logic [3:0]         skip_flags_d;
  logic [CNT_W-1:0]   cnt_load_d;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign state_o   = state_q;
  assign calc_a    = calc_a_q;
  assign calc_b    = calc_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;

  // Select the datapath result and flags for the latched opcode at capture time.
  always_comb begin
    cap_data_d  = 64'd0;
    cap_flags_d = 4'b0000;
    case (op_q)
      OP_ADD: begin
        cap_data_d  = {32'd0, int_add};
        cap_flags_d = {2'b00, addCy, addCo};
      end
      OP_SUB: begin
        cap_data_d  = {32'd0, int_sub};
        cap_flags_d = {2'b00, subCy, subCo};
      end
      OP_MUL: cap_data_d = int_mul;
      OP_DIV: cap_data_d = {32'd0, int_div};
      OP_MOD: cap_data_d = {32'd0, int_mod};
      default: cap_flags_d = 4'b1000;
    endcase
  end

  // Classify the incoming request. Work out the immediate response for
  // illegal ops and divide-by-zero, and the latency to wait for real ops.
  always_comb begin
    req_illegal  = (req_op > OP_MOD);
    req_dbz      = ((req_op == OP_DIV) || (req_op == OP_MOD)) && (req_b == 32'd0);
    skip_data_d  = 64'd0;
    skip_flags_d = 4'b1000;
    if (!req_illegal) begin
      skip_flags_d = 4'b0100;
      if (req_op == OP_DIV) skip_data_d = 64'h0000_0000_FFFF_FFFF;
      else                  skip_data_d = {32'd0, req_a[31:0]};
    end
    case (req_op)
      OP_ADD, OP_SUB: cnt_load_d = CNT_W'(1);
      OP_MUL:         cnt_load_d = CNT_W'(MUL_LAT);
      default:        cnt_load_d = CNT_W'(DIV_LAT);
    endcase
  end

  // Sequencer FSM: accept, hold operands, count down the latency, hold the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      cnt_q       <= '0;
      calc_a_q    <= 64'd0;
      calc_b_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 64'd0;
      rsp_flags_q <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            calc_a_q <= req_a;
            calc_b_q <= req_b;
            if (req_illegal || req_dbz) begin
              // The divider never sees a zero divisor. Answer straight away.
              rsp_data_q  <= skip_data_d;
              rsp_flags_q <= skip_flags_d;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              cnt_q   <= cnt_load_d;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rsp_data_q  <= cap_data_d;
            rsp_flags_q <= cap_flags_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_calc_ctrl.sv
// Testbench for int_calc_ctrl. The bench models the datapath with fixed
// latencies: the multiply and divide outputs read as garbage until they have
// had their full latency. Expected responses go into queues when a request
// is driven and are checked when the response appears.
module tb_int_calc_ctrl;

  localparam int MUL_LAT = 6;
  localparam int DIV_LAT = 36;
  localparam int CNT_W   = 6;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [31:0] req_b;
  logic [63:0] calc_a;
  logic [31:0] calc_b;
  logic [31:0] int_add;
  logic [31:0] int_sub;
  logic [63:0] int_mul;
  logic [31:0] int_div;
  logic [31:0] int_mod;
  logic        addCo;
  logic        addCy;
  logic        subCo;
  logic        subCy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        busy;
  logic [1:0]  state_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int age = 255;
  int accept_cnt = 0;
  bit hold_valid = 0;

  logic [63:0] exp_data_q[$];
  logic [3:0]  exp_flags_q[$];
  logic [7:0]  exp_lat_q[$];

  int_calc_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .calc_a(calc_a), .calc_b(calc_b),
    .int_add(int_add), .int_sub(int_sub), .int_mul(int_mul),
    .int_div(int_div), .int_mod(int_mod),
    .addCo(addCo), .addCy(addCy), .subCo(subCo), .subCy(subCy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since the last accepted request, and the number of accepts.
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      age        <= 0;
      accept_cnt <= accept_cnt + 1;
    end else if (age < 255) begin
      age <= age + 1;
    end
  end

  // ---------------- datapath model ----------------
  logic [32:0] add_full;
  logic [32:0] sub_full;
  assign add_full = {1'b0, calc_a[31:0]} + {1'b0, calc_b};
  assign sub_full = {1'b0, calc_a[31:0]} + {1'b0, ~calc_b} + 33'd1;
  assign int_add  = add_full[31:0];
  assign addCo    = add_full[32];
  assign addCy    = (calc_a[31] == calc_b[31]) && (add_full[31] != calc_a[31]);
  assign int_sub  = sub_full[31:0];
  assign subCo    = sub_full[32];
  assign subCy    = (calc_a[31] != calc_b[31]) && (sub_full[31] != calc_a[31]);
  assign int_mul  = (age >= MUL_LAT - 1) ? ({32'd0, calc_a[31:0]} * {32'd0, calc_b})
                                         : 64'hBAD0_BAD0_BAD0_BAD0;
  assign int_div  = (age >= DIV_LAT - 1 && calc_b != 0) ? 32'(calc_a / {32'd0, calc_b})
                                                        : 32'hBAD0_BAD0;
  assign int_mod  = (age >= DIV_LAT - 1 && calc_b != 0) ? 32'(calc_a % {32'd0, calc_b})
                                                        : 32'hBAD1_BAD1;

  // ---------------- driver tasks ----------------
  // Push the expected response, present the request and return #1 after the accept edge.
  task automatic drive_req(input logic [2:0] op, input logic [63:0] a, input logic [31:0] b,
                           input logic [63:0] ed, input logic [3:0] ef, input logic [7:0] el);
    int n;
    exp_data_q.push_back(ed);
    exp_flags_q.push_back(ef);
    exp_lat_q.push_back(el);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = 1'b0;
  endtask

  // Count the edges after the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat, output logic [63:0] d, output logic [3:0] f);
    lat = 0;
    while (!rsp_valid && lat <= 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = rsp_data;
    f = rsp_flags;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({calc_a, calc_b, rsp_data, rsp_flags, rsp_valid, busy, req_ready, state_o} !==
        {64'd0, 32'd0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      $display("FAIL reset_state: calc_a=%h calc_b=%h data=%h flags=%b valid=%b busy=%b ready=%b state=%0d, need zeros with ready=1",
               calc_a, calc_b, rsp_data, rsp_flags, rsp_valid, busy, req_ready, state_o);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One table drives every single-response case. Each response is checked for latency, data and flags.
  task automatic test_ops();
    logic [2:0]  ops [12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd6, 3'd7};
    logic [63:0] as  [12] = '{64'hFFFF_FFFF, 64'h7FFF_FFFF, 64'd5, 64'd7, 64'hFFFF_FFFF, 64'd100,
                              64'd100, 64'h1_0000_0000, 64'h1_2345_6789, 64'd55, 64'd9, 64'd9};
    logic [31:0] bs  [12] = '{32'd1, 32'd1, 32'd7, 32'd5, 32'hFFFF_FFFF, 32'd7,
                              32'd7, 32'd2, 32'd0, 32'd0, 32'd3, 32'd3};
    logic [63:0] eds [12] = '{64'd0, 64'h8000_0000, 64'hFFFF_FFFE, 64'd2, 64'hFFFF_FFFE_0000_0001, 64'd14,
                              64'd2, 64'h8000_0000, 64'h2345_6789, 64'hFFFF_FFFF, 64'd0, 64'd0};
    logic [3:0]  efs [12] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    logic [7:0]  els [12] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'(MUL_LAT), 8'(DIV_LAT),
                              8'(DIV_LAT), 8'(DIV_LAT), 8'd0, 8'd0, 8'd0, 8'd0};
    int lat;
    logic [63:0] d, ed;
    logic [3:0]  f, ef;
    logic [7:0]  el;
    for (int i = 0; i < 12; i++) begin
      drive_req(ops[i], as[i], bs[i], eds[i], efs[i], els[i]);
      wait_rsp(lat, d, f);
      ed = exp_data_q.pop_front();
      ef = exp_flags_q.pop_front();
      el = exp_lat_q.pop_front();
      total_cnt++;
      if (lat !== int'(el)) $display("FAIL op_latency case %0d op %0d: got %0d cycles, need %0d", i, ops[i], lat, el);
      else pass_cnt++;
      total_cnt++;
      if (d !== ed) $display("FAIL op_data case %0d op %0d: got %h, need %h", i, ops[i], d, ed);
      else pass_cnt++;
      total_cnt++;
      if (f !== ef) $display("FAIL op_flags case %0d op %0d: got %b, need %b", i, ops[i], f, ef);
      else pass_cnt++;
      release_rsp();
    end
  endtask

  // Keep req_valid high through a divide. Only one request may be accepted.
  task automatic test_busy_ignore();
    int base, bad, lat;
    logic [63:0] d, ed;
    logic [3:0]  f, ef;
    logic [7:0]  el;
    base = accept_cnt;
    hold_valid = 1;
    drive_req(3'd3, 64'd1000, 32'd3, 64'd333, 4'b0000, 8'(DIV_LAT));
    hold_valid = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    total_cnt++;
    if (bad != 0) $display("FAIL busy_ready: %0d cycles with ready high or busy low, need 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (accept_cnt - base != 1) $display("FAIL busy_accepts: got %0d accepts, need 1", accept_cnt - base);
    else pass_cnt++;
    wait_rsp(lat, d, f);
    lat = lat + 20;
    ed = exp_data_q.pop_front();
    ef = exp_flags_q.pop_front();
    el = exp_lat_q.pop_front();
    total_cnt++;
    if (lat !== int'(el) || d !== ed || f !== ef)
      $display("FAIL busy_result: got lat %0d data %h flags %b, need lat %0d data %h flags %b", lat, d, f, el, ed, ef);
    else pass_cnt++;
    release_rsp();
  endtask

  // Stall the consumer in DONE. Then issue a request during the handshake cycle.
  task automatic test_back_to_back();
    int lat, bad, base;
    logic [63:0] d, ed;
    logic [3:0]  f, ef;
    logic [7:0]  el;
    drive_req(3'd0, 64'h10, 32'h20, 64'h30, 4'b0000, 8'd1);
    wait_rsp(lat, d, f);
    ed = exp_data_q.pop_front();
    ef = exp_flags_q.pop_front();
    el = exp_lat_q.pop_front();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_flags !== ef) bad++;
    end
    total_cnt++;
    if (bad != 0 || lat !== int'(el))
      $display("FAIL hold_stable: %0d unstable cycles, lat %0d, need 0 and %0d", bad, lat, el);
    else pass_cnt++;
    // Drive the next request during the handshake cycle.
    exp_data_q.push_back(64'd5);
    exp_flags_q.push_back(4'b0001);
    exp_lat_q.push_back(8'd1);
    base = accept_cnt;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_op = 3'd1; req_a = 64'd9; req_b = 32'd4; req_valid = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if (accept_cnt != base || rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL handshake_cycle: accepts %0d valid %b ready %b, need 0 0 1", accept_cnt - base, rsp_valid, req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total_cnt++;
    if (accept_cnt != base + 1) $display("FAIL next_accept: got %0d accepts, need 1", accept_cnt - base);
    else pass_cnt++;
    wait_rsp(lat, d, f);
    ed = exp_data_q.pop_front();
    ef = exp_flags_q.pop_front();
    el = exp_lat_q.pop_front();
    total_cnt++;
    if (lat !== int'(el) || d !== ed || f !== ef)
      $display("FAIL b2b_sub: got lat %0d data %h flags %b, need lat %0d data %h flags %b", lat, d, f, el, ed, ef);
    else pass_cnt++;
    release_rsp();
    drive_req(3'd2, 64'd3, 32'd5, 64'd15, 4'b0000, 8'(MUL_LAT));
    wait_rsp(lat, d, f);
    ed = exp_data_q.pop_front();
    ef = exp_flags_q.pop_front();
    el = exp_lat_q.pop_front();
    total_cnt++;
    if (lat !== int'(el) || d !== ed || f !== ef)
      $display("FAIL b2b_mul: got lat %0d data %h flags %b, need lat %0d data %h flags %b", lat, d, f, el, ed, ef);
    else pass_cnt++;
    release_rsp();
  endtask

  // Reset while a divide is in WAIT. No stale response may follow.
  task automatic test_reset_mid_wait();
    int lat, seen;
    logic [63:0] d, ed;
    logic [3:0]  f, ef;
    logic [7:0]  el;
    drive_req(3'd3, 64'd1000, 32'd3, 64'd333, 4'b0000, 8'(DIV_LAT));
    void'(exp_data_q.pop_front());
    void'(exp_flags_q.pop_front());
    void'(exp_lat_q.pop_front());
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({calc_a, calc_b, rsp_data, rsp_flags, rsp_valid, busy, req_ready, state_o} !==
        {64'd0, 32'd0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0})
      $display("FAIL reset_mid_wait: calc_a=%h calc_b=%h data=%h flags=%b valid=%b busy=%b ready=%b, need zeros with ready=1",
               calc_a, calc_b, rsp_data, rsp_flags, rsp_valid, busy, req_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(3'd0, 64'd3, 32'd4, 64'd7, 4'b0000, 8'd1);
    wait_rsp(lat, d, f);
    ed = exp_data_q.pop_front();
    ef = exp_flags_q.pop_front();
    el = exp_lat_q.pop_front();
    total_cnt++;
    if (lat !== int'(el) || d !== ed || f !== ef)
      $display("FAIL post_reset_add: got lat %0d data %h flags %b, need lat %0d data %h flags %b", lat, d, f, el, ed, ef);
    else pass_cnt++;
    release_rsp();
    seen = 0;
    for (int i = 0; i < DIV_LAT + 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL stale_response: rsp_valid high %0d cycles, need 0", seen);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'd0; req_a = 64'd0; req_b = 32'd0;
    test_reset();
    test_ops();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_wait();
    total_cnt++;
    if (exp_data_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_data_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
